pmem_responder: RTL and testbench

Burst physical-memory responder: the memory end of the L2-to-physical-memory handshake (read/write/address/wdata in, resp/rdata out).
- Holds DEPTH 128-bit lines (lc3b_burst) and answers each request after a fixed, parameterised latency.
- Used as the synthesizable memory model under the DGM top in simulation and in FPGA bring-up.
- Supplies the deterministic timing that the cache miss counters are checked against.

---
 rtl/pmem_responder.sv | 136 +++++++++++++
 tb/tb_pmem_responder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_responder.sv
// Burst physical-memory responder: fixed-latency line store answering L2 read/write requests.
// Optional build macro PMEM_STATS_EN adds saturating read_count/write_count outputs.
module pmem_responder #(
    parameter int LATENCY  = 10,
    parameter int IDX_BITS = 5
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         read,
    input  logic         write,
    input  logic [15:0]  address,
    input  logic [127:0] wdata,
    output logic         resp,
    output logic [127:0] rdata,
    output logic         protocol_err
`ifdef PMEM_STATS_EN
    ,
    output logic [15:0]  read_count,
    output logic [15:0]  write_count
`endif
);

    localparam int         DEPTH  = 2 ** IDX_BITS;
    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                r_state;
    logic [7:0]            r_cnt;
    logic                  r_opWrite;
    logic [IDX_BITS-1:0]   r_idx;
    logic [127:0]          r_wdata;
    logic                  r_resp;
    logic [127:0]          r_rdata;
    logic                  r_perr;
    logic [127:0]          r_mem [DEPTH];

    logic [IDX_BITS-1:0]   w_idx;
    logic                  w_req;
    logic                  w_keep;
    logic                  w_unused_addr;

    assign w_idx         = address[IDX_BITS+3:4];
    assign w_req         = read | write;
    assign w_keep        = r_opWrite ? write : read;
    assign w_unused_addr = ^{address[15:IDX_BITS+4], address[3:0]};

    assign resp         = r_resp;
    assign rdata        = r_rdata;
    assign protocol_err = r_perr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_opWrite <= 1'b0;
            r_idx     <= '0;
            r_wdata   <= '0;
            r_resp    <= 1'b0;
            r_rdata   <= '0;
            r_perr    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_resp  <= 1'b0;
                    r_rdata <= '0;
                    if (w_req) begin
                        r_opWrite <= write;
                        r_idx     <= w_idx;
                        r_wdata   <= wdata;
                        r_cnt     <= LAT_M1;
                        if (read && write)
                            r_perr <= 1'b1;
                        if (LATENCY == 1) begin
                            r_state <= RESP;
                            r_resp  <= 1'b1;
                            r_rdata <= write ? '0 : r_mem[w_idx];
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // Move to RESP on the edge where the counter reaches zero, so resp lands LATENCY cycles after acceptance.
                    if (!w_keep) begin
                        r_state <= IDLE;
                    end else if (r_cnt <= 8'd1) begin
                        r_state <= RESP;
                        r_cnt   <= '0;
                        r_resp  <= 1'b1;
                        r_rdata <= r_opWrite ? '0 : r_mem[r_idx];
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_resp  <= 1'b0;
                    r_rdata <= '0;
                end
                default: begin
                    r_state <= IDLE;
                    r_resp  <= 1'b0;
                    r_rdata <= '0;
                end
            endcase
        end
    end

    // Line array is deliberately unreset; a write only lands on the edge leaving RESP.
    always_ff @(posedge clk) begin
        if (r_state == RESP && r_opWrite)
            r_mem[r_idx] <= r_wdata;
    end

`ifdef PMEM_STATS_EN
    logic [15:0] r_readCount;
    logic [15:0] r_writeCount;

    assign read_count  = r_readCount;
    assign write_count = r_writeCount;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readCount  <= '0;
            r_writeCount <= '0;
        end else if (r_state == RESP) begin
            if (r_opWrite && r_writeCount != 16'hFFFF)
                r_writeCount <= r_writeCount + 16'd1;
            else if (!r_opWrite && r_readCount != 16'hFFFF)
                r_readCount <= r_readCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// Self-checking bench for pmem_responder: a LATENCY=10 instance for the main scenarios and a
// LATENCY=1 instance for held back-to-back reads; expected read lines go through a scoreboard queue.
module tb_pmem_responder;

    localparam int LAT = 10;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         read, write;
    logic [15:0]  address;
    logic [127:0] wdata;
    logic         resp;
    logic [127:0] rdata;
    logic         protocolErr;

    logic         read1, write1;
    logic [15:0]  address1;
    logic [127:0] wdata1;
    logic         resp1;
    logic [127:0] rdata1;
    logic         protocolErr1;

`ifdef PMEM_STATS_EN
    logic [15:0]  readCount, writeCount, readCount1, writeCount1;
`endif

    int total = 0;
    int bad   = 0;
    logic [127:0] expQ [$];

    always #5 clk = ~clk;

    pmem_responder #(.LATENCY(LAT), .IDX_BITS(5)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .read         (read),
        .write        (write),
        .address      (address),
        .wdata        (wdata),
        .resp         (resp),
        .rdata        (rdata),
        .protocol_err (protocolErr)
`ifdef PMEM_STATS_EN
        ,
        .read_count   (readCount),
        .write_count  (writeCount)
`endif
    );

    pmem_responder #(.LATENCY(1), .IDX_BITS(5)) dut1 (
        .clk          (clk),
        .reset_n      (reset_n),
        .read         (read1),
        .write        (write1),
        .address      (address1),
        .wdata        (wdata1),
        .resp         (resp1),
        .rdata        (rdata1),
        .protocol_err (protocolErr1)
`ifdef PMEM_STATS_EN
        ,
        .read_count   (readCount1),
        .write_count  (writeCount1)
`endif
    );

    // Drives one request on the LATENCY=10 instance, scrambles address/wdata after acceptance, waits for resp.
    task automatic issue(input bit isRd, input bit isWr, input logic [15:0] addr, input logic [127:0] wd,
                         output int lat, output logic [127:0] rd, output bit got);
        @(negedge clk);
        read = isRd; write = isWr; address = addr; wdata = wd;
        got = 1'b0; lat = 0; rd = '0;
        for (int c = 1; c <= 3 * LAT && !got; c++) begin
            @(negedge clk);
            if (c == 1) begin
                address = ~addr;
                wdata   = ~wd;
            end
            if (resp === 1'b1) begin
                got = 1'b1;
                lat = c;
                rd  = rdata;
            end
        end
        read = 1'b0; write = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        read = 0; write = 0; address = '0; wdata = '0;
        read1 = 0; write1 = 0; address1 = '0; wdata1 = '0;
        repeat (2) @(negedge clk);
        total++; if (resp !== 1'b0) begin bad++; $display("[TB] FAIL reset_resp got=%b want=0", resp); end
        total++; if (rdata !== '0) begin bad++; $display("[TB] FAIL reset_rdata got=%h want=0", rdata); end
        total++; if (protocolErr !== 1'b0) begin bad++; $display("[TB] FAIL reset_perr got=%b want=0", protocolErr); end
        total++; if (resp1 !== 1'b0) begin bad++; $display("[TB] FAIL reset_resp1 got=%b want=0", resp1); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Write-phase response (rdata 0) then a read of the same line; checks latency and scoreboard data.
    task automatic test_write_read();
        int lat; logic [127:0] rd, exp; bit got;
        logic [127:0] v = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        expQ.push_back('0);
        issue(0, 1, 16'h0040, v, lat, rd, got);
        exp = expQ.pop_front();
        total++; if (!got || lat != LAT) begin bad++; $display("[TB] FAIL wr_latency got=%0d want=%0d", lat, LAT); end
        total++; if (rd !== exp) begin bad++; $display("[TB] FAIL wr_rdata got=%h want=%h", rd, exp); end
        expQ.push_back(v);
        issue(1, 0, 16'h004C, 128'hDEAD, lat, rd, got);
        exp = expQ.pop_front();
        total++; if (!got || lat != LAT) begin bad++; $display("[TB] FAIL rd_latency got=%0d want=%0d", lat, LAT); end
        total++; if (rd !== exp) begin bad++; $display("[TB] FAIL rd_data got=%h want=%h", rd, exp); end
        @(negedge clk);
        total++; if (rdata !== '0 || resp !== 1'b0) begin bad++; $display("[TB] FAIL rd_idle got=%b/%h want=0/0", resp, rdata); end
    endtask

    task automatic test_alias();
        int lat; logic [127:0] rd, exp; bit got;
        logic [127:0] a = 128'hAAAA_5555_1234_5678_9ABC_DEF0_0F0F_F0F0;
        issue(0, 1, 16'h0200, a, lat, rd, got);
        total++; if (!got) begin bad++; $display("[TB] FAIL alias_wr_timeout got=0 want=1"); end
        expQ.push_back(a);
        issue(1, 0, 16'h0000, '0, lat, rd, got);
        exp = expQ.pop_front();
        total++; if (!got || rd !== exp) begin bad++; $display("[TB] FAIL alias_rdata got=%h want=%h", rd, exp); end
    endtask

    task automatic test_abort();
        int lat; logic [127:0] rd, exp; bit got, seen;
        logic [127:0] b = 128'hBBBB_0000_1111_2222_3333_4444_5555_6666;
        @(negedge clk);
        read = 1'b1; address = 16'h0010;
        repeat (3) @(negedge clk);
        read = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 2 * LAT; c++) begin
            @(negedge clk);
            if (resp !== 1'b0) seen = 1'b1;
        end
        total++; if (seen) begin bad++; $display("[TB] FAIL abort_resp got=1 want=0"); end
        issue(0, 1, 16'h0010, b, lat, rd, got);
        total++; if (!got || lat != LAT) begin bad++; $display("[TB] FAIL abort_wr_latency got=%0d want=%0d", lat, LAT); end
        expQ.push_back(b);
        issue(1, 0, 16'h0018, '0, lat, rd, got);
        exp = expQ.pop_front();
        total++; if (!got || rd !== exp) begin bad++; $display("[TB] FAIL abort_rdata got=%h want=%h", rd, exp); end
    endtask

    task automatic test_reset_mid_write();
        int lat; logic [127:0] rd, exp; bit got, seen;
        logic [127:0] e = 128'hEEEE_EEEE_0000_1111_2222_3333_4444_5555;
        logic [127:0] d = 128'hDDDD_DDDD_9999_8888_7777_6666_5555_4444;
        issue(0, 1, 16'h0070, e, lat, rd, got);
        total++; if (!got) begin bad++; $display("[TB] FAIL rst_pre_wr_timeout got=0 want=1"); end
        @(negedge clk);
        write = 1'b1; address = 16'h0070; wdata = d;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        total++; if (resp !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_resp got=%b want=0", resp); end
        @(negedge clk);
        reset_n = 1'b1; write = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 2 * LAT; c++) begin
            @(negedge clk);
            if (resp !== 1'b0) seen = 1'b1;
        end
        total++; if (seen) begin bad++; $display("[TB] FAIL rst_no_resp got=1 want=0"); end
        expQ.push_back(e);
        issue(1, 0, 16'h0074, '0, lat, rd, got);
        exp = expQ.pop_front();
        total++; if (!got || rd !== exp) begin bad++; $display("[TB] FAIL rst_line_kept got=%h want=%h", rd, exp); end
    endtask

    task automatic test_simultaneous();
        int lat; logic [127:0] rd, exp; bit got;
        logic [127:0] cval = 128'hCCCC_1234_CCCC_5678_CCCC_9ABC_CCCC_DEF0;
        expQ.push_back('0);
        issue(1, 1, 16'h0030, cval, lat, rd, got);
        exp = expQ.pop_front();
        total++; if (!got || lat != LAT) begin bad++; $display("[TB] FAIL both_latency got=%0d want=%0d", lat, LAT); end
        total++; if (rd !== exp) begin bad++; $display("[TB] FAIL both_rdata got=%h want=%h", rd, exp); end
        total++; if (protocolErr !== 1'b1) begin bad++; $display("[TB] FAIL both_perr got=%b want=1", protocolErr); end
        expQ.push_back(cval);
        issue(1, 0, 16'h0030, '0, lat, rd, got);
        exp = expQ.pop_front();
        total++; if (!got || rd !== exp) begin bad++; $display("[TB] FAIL both_readback got=%h want=%h", rd, exp); end
        total++; if (protocolErr !== 1'b1) begin bad++; $display("[TB] FAIL perr_sticky got=%b want=1", protocolErr); end
    endtask

    // LATENCY=1: write once, then hold read high and expect resp on every second cycle.
    task automatic test_back_to_back();
        logic [127:0] w = 128'h5A5A_A5A5_0102_0304_0506_0708_090A_0B0C;
        logic [127:0] exp;
        bit expResp;
        int pulses = 0;
        @(negedge clk);
        write1 = 1'b1; address1 = 16'h0050; wdata1 = w;
        @(negedge clk);
        total++; if (resp1 !== 1'b1) begin bad++; $display("[TB] FAIL b2b_wr_resp got=%b want=1", resp1); end
        write1 = 1'b0; wdata1 = '0;
        @(negedge clk);
        read1 = 1'b1;
        for (int i = 0; i < 6; i++) expQ.push_back(w);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            expResp = (k % 2) == 1;
            total++; if (resp1 !== expResp) begin bad++; $display("[TB] FAIL b2b_resp k=%0d got=%b want=%b", k, resp1, expResp); end
            if (resp1 === 1'b1) begin
                pulses++;
                if (expQ.size() == 0) begin
                    total++; bad++; $display("[TB] FAIL b2b_extra got=resp want=none");
                end else begin
                    exp = expQ.pop_front();
                    total++; if (rdata1 !== exp) begin bad++; $display("[TB] FAIL b2b_rdata k=%0d got=%h want=%h", k, rdata1, exp); end
                end
            end
            if (k == 12) read1 = 1'b0;
        end
        total++; if (expQ.size() != 0) begin bad++; $display("[TB] FAIL b2b_missing got=%0d want=0", expQ.size()); end
        expQ.delete();
        repeat (2) @(negedge clk);
`ifdef PMEM_STATS_EN
        total++; if (readCount1 !== 16'(pulses)) begin bad++; $display("[TB] FAIL stats_rd got=%0d want=%0d", readCount1, pulses); end
        total++; if (writeCount1 !== 16'd1) begin bad++; $display("[TB] FAIL stats_wr got=%0d want=1", writeCount1); end
`endif
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_alias();
        test_abort();
        test_reset_mid_write();
        test_simultaneous();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
